// File: rtl/bram_ring_writer.sv
// rtl/bram_ring_writer.sv - Port-A circular-buffer writer for the acquisition sample BRAM
module bram_ring_writer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8192,
    parameter int PTR_WIDTH  = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    ptr_clear,
    input  logic [PTR_WIDTH-1:0]    rd_ptr,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_last,
    output logic                    bram_en,
    output logic [DATA_WIDTH/8-1:0] bram_we,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]   bram_din,
    output logic [PTR_WIDTH-1:0]    wr_ptr,
    output logic                    half_irq,
    output logic                    overflow,
    input  logic                    overflow_clr,
    output logic [31:0]             frame_count,
    output logic                    busy
);

    localparam int BE_WIDTH   = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BE_WIDTH);
    localparam int FULL_AW    = PTR_WIDTH + BYTE_SHIFT;
    localparam logic [PTR_WIDTH-1:0] HALF_IDX = PTR_WIDTH'(DEPTH / 2 - 1);
    localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PTR_WIDTH-1:0]   ip;
    logic [PTR_WIDTH-1:0]   ip_inc;
    logic                   frame_open;
    logic                   frame_open_next;
    logic                   active;
    logic                   full;
    logic                   accept;
    logic [PTR_WIDTH-1:0]   pend_idx;
    logic                   pend_last;
    logic [FULL_AW-1:0]     addr_full;

    // Ready depends only on registered state, the accept pointer and the PS read pointer.
    // One slot is always left empty so rd_ptr == ip can only ever mean "empty".
    assign ip_inc    = ip + PTR_WIDTH'(1);
    assign full      = (ip_inc == rd_ptr);
    assign active    = (state == RUN) || (state == FINISH);
    assign s_ready   = active && !full;
    assign accept    = s_valid && s_ready;
    assign busy      = (state != IDLE);
    assign addr_full = {ip, {BYTE_SHIFT{1'b0}}};

    // Frame-open tracking, looking through this cycle's accept so a stop request
    // in the same cycle as s_last goes straight to IDLE.
    always_comb begin
        frame_open_next = frame_open;
        if (accept) begin
            frame_open_next = !s_last;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a stop request lets an open frame drain to its s_last first.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = frame_open_next ? FINISH : IDLE;
                end
            end
            FINISH: begin
                if (accept && s_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Accept side: launch the BRAM write and advance the internal pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip         <= '0;
            frame_open <= 1'b0;
            bram_en    <= 1'b0;
            bram_we    <= '0;
            bram_addr  <= '0;
            bram_din   <= '0;
            pend_idx   <= '0;
            pend_last  <= 1'b0;
        end else begin
            frame_open <= frame_open_next;
            bram_en    <= accept;
            bram_we    <= accept ? {BE_WIDTH{1'b1}} : '0;
            if (accept) begin
                bram_addr <= ADDR_WIDTH'(addr_full);
                bram_din  <= s_data;
                pend_idx  <= ip;
                pend_last <= s_last;
                ip        <= ip_inc;
            end else if (state == IDLE && ptr_clear) begin
                ip <= '0;
            end
        end
    end

    // Commit side: the word lands in BRAM this edge, so publish progress and events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            half_irq    <= 1'b0;
            frame_count <= '0;
        end else begin
            half_irq <= bram_en && ((pend_idx == HALF_IDX) || (pend_idx == LAST_IDX));
            if (bram_en && pend_last) begin
                frame_count <= frame_count + 32'd1;
            end
            if (state == IDLE && ptr_clear) begin
                wr_ptr <= '0;
            end else if (bram_en) begin
                wr_ptr <= pend_idx + PTR_WIDTH'(1);
            end
        end
    end

    // Sticky overflow flag; a new offer against a full buffer beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (s_valid && full && active) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: doc/bram_ring_writer.md
Name: bram_ring_writer

Overview:
- Port-A writer for the acquisition sample BRAM (write side of the dual-port buffer whose port B is read over AXI by the PS).
- Accepts a valid/ready stream of 64-bit sample words and writes them into the BRAM as a circular buffer.
- Applies backpressure against a PS-supplied read pointer, reports write progress, raises half/full-buffer pulses and counts completed frames.

Parameters:
ADDR_WIDTH, 16, BRAM byte-address width (matches BRAM port A addr).
DATA_WIDTH, 64, word width; byte-enable width = DATA_WIDTH/8.
DEPTH, 8192, buffer depth in words; power of two, >=4.
PTR_WIDTH, 13, word-index width, = log2(DEPTH).

Ports:
clk  in  1  single clock for all logic and BRAM port A.
rst_n  in  1  asynchronous, active-low reset.
enable  in  1  capture enable from PS control register.
ptr_clear  in  1  zeroes write pointer; honoured only in IDLE.
rd_ptr  in  PTR_WIDTH  PS consumer word index (next word PS will read), same clock domain.
s_valid  in  1  input word valid.
s_ready  out  1  writer can accept.
s_data  in  DATA_WIDTH  input word.
s_last  in  1  marks final word of a frame.
bram_en  out  1  BRAM port A enable.
bram_we  out  DATA_WIDTH/8  BRAM port A byte write enables.
bram_addr  out  ADDR_WIDTH  BRAM port A byte address.
bram_din  out  DATA_WIDTH  BRAM port A write data.
wr_ptr  out  PTR_WIDTH  committed word index (next to be written).
half_irq  out  1  one-cycle pulse at half/end-of-buffer commit.
overflow  out  1  sticky: word offered while buffer full.
overflow_clr  in  1  clears overflow.
frame_count  out  32  frames committed since reset.
busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low, async): state IDLE, all outputs 0, internal pointer 0, frame_count 0.
- States:
  - IDLE: s_ready=0. enable=1 -> RUN. ptr_clear=1 (in IDLE only) zeroes internal pointer and wr_ptr next edge.
  - RUN: accepts words. enable=0 with no frame open -> IDLE. enable=0 with frame open -> FINISH.
  - FINISH: accepts words until s_last accepted -> IDLE.
  - A frame is open from the first accepted word after the previous s_last (or after reset) until its s_last.
- full = ((ip + 1) mod DEPTH) == rd_ptr, where ip is the internal (accept-side) pointer. Capacity is DEPTH-1 words.
- s_ready = (state RUN or FINISH) && !full; it is a function of registered state only (no s_valid in path).
- Accept (s_valid && s_ready) at edge N:
  - After edge N: bram_en=1, bram_we=all ones, bram_addr={ip,3'b000} truncated to ADDR_WIDTH, bram_din=s_data. The write lands at edge N+1.
  - ip increments mod DEPTH at edge N.
- Commit at edge N+1:
  - wr_ptr <= written index + 1 mod DEPTH.
  - half_irq=1 for one cycle if the written index was DEPTH/2-1 or DEPTH-1.
  - frame_count increments (wraps at 2^32) if the word carried s_last.
- No accept: bram_en=0, bram_we=0; bram_addr/bram_din hold.
- Back-to-back accepts: one word per cycle, no bubbles.
- Overflow: set when s_valid=1 && full && state in RUN/FINISH. overflow_clr clears it; a simultaneous set wins. Overflow never drops data; the stream is held.
- Wrap: ip and wr_ptr wrap DEPTH-1 -> 0; bram_addr wraps to 0.
- rd_ptr changes take effect on s_ready the next cycle after they are registered by the upstream PS register. rd_ptr == ip means empty; the writer never reads it as full.
- enable toggling while IDLE with no s_valid has no side effects.
- Async reset mid-burst: in-flight write is abandoned; bram_en and bram_we drop immediately.

Test Plan:
1. Reset: rst_n=0 mid-sim -> s_ready, bram_en, bram_we, wr_ptr, overflow, frame_count, busy all 0 asynchronously.
2. Basic write: enable=1, rd_ptr=0, push 0xA0..0xA3 -> bram_addr 0x0000/0x0008/0x0010/0x0018, bram_we=0xFF, one-cycle latency, wr_ptr=4 one cycle after last accept.
3. Full/backpressure (DEPTH=16, rd_ptr=0): s_valid held for 20 words -> 15 accepted, s_ready=0, overflow=1; set rd_ptr=8 -> next word written at addr 0x78, then addr wraps to 0x00; overflow stays 1 until overflow_clr.
4. Half/wrap irq (DEPTH=16, rd_ptr advanced by bench): 32 words -> half_irq pulses 4 times, on commits of indices 7, 15, 7, 15; frame_count counts s_last every 8th word = 4.
5. Graceful stop: s_last on 7th word, enable=0 after 3rd accept -> state FINISH, words 4-7 accepted, then IDLE with s_ready=0, frame_count=1, busy=0.
6. ptr_clear: in IDLE with wr_ptr=9, pulse ptr_clear -> wr_ptr=0 next edge; ptr_clear during RUN -> ignored.
